// File: rtl/decodec_unit_pkg.sv
// Shared ISA definitions for the A/B accumulator decoder: opcodes, load-source
// select codes, flag bit positions and the combinational decode table.
package decodec_unit_pkg;

  typedef enum logic [5:0] {
    OP_NOP   = 6'h00,
    OP_LDA   = 6'h01,
    OP_LDB   = 6'h02,
    OP_LDCA  = 6'h03,
    OP_LDCB  = 6'h04,
    OP_STA   = 6'h05,
    OP_STB   = 6'h06,
    OP_ADDA  = 6'h07,
    OP_ADDB  = 6'h08,
    OP_SUBA  = 6'h09,
    OP_SUBB  = 6'h0A,
    OP_ANDA  = 6'h0B,
    OP_ORA   = 6'h0C,
    OP_JMP   = 6'h0D,
    OP_BAZ   = 6'h0E,
    OP_BBZ   = 6'h0F,
    OP_BAN   = 6'h10,
    OP_BAC   = 6'h11,
    OP_ADDCA = 6'h12,
    OP_ADDCB = 6'h13
  } op_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_ALU  = 2'b01,
    SEL_INM  = 2'b10,
    SEL_MEM  = 2'b11
  } sel_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;

  typedef struct packed {
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       sel_m1;
    logic       sel_m2;
    logic       wr_enable;
    logic       jmp_enable;
    logic       branch_enable;
  } ctrl_t;

  // Unlisted opcodes fall through to the all-zero (NOP/hold) control word.
  function automatic ctrl_t decode(input logic [5:0] opc,
                                   input logic [2:0] flag_a,
                                   input logic [2:0] flag_b);
    ctrl_t c;
    c = '0;
    case (opc)
      OP_LDA:   c.sel_a = SEL_MEM;
      OP_LDB:   c.sel_b = SEL_MEM;
      OP_LDCA:  c.sel_a = SEL_INM;
      OP_LDCB:  c.sel_b = SEL_INM;
      OP_STA:   c.wr_enable = 1'b1;
      OP_STB: begin
        c.wr_enable = 1'b1;
        c.sel_m1    = 1'b1;
      end
      OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA: c.sel_a = SEL_ALU;
      OP_ADDB, OP_SUBB:                  c.sel_b = SEL_ALU;
      OP_JMP:   c.jmp_enable    = 1'b1;
      OP_BAZ:   c.branch_enable = flag_a[FLAG_Z];
      OP_BBZ:   c.branch_enable = flag_b[FLAG_Z];
      OP_BAN:   c.branch_enable = flag_a[FLAG_N];
      OP_BAC:   c.branch_enable = flag_a[FLAG_C];
      OP_ADDCA: begin
        c.sel_a  = SEL_ALU;
        c.sel_m2 = 1'b1;
      end
      OP_ADDCB: begin
        c.sel_b  = SEL_ALU;
        c.sel_m2 = 1'b1;
      end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decodec_unit_if.sv
// Instruction/flag inputs and decoded control/field outputs of the decoder.
interface decodec_unit_if;
  logic [15:0] in;
  logic [2:0]  flagA;
  logic [2:0]  flagB;
  logic [1:0]  selA;
  logic [1:0]  selB;
  logic        selM1;
  logic        selM2;
  logic        wrEnable;
  logic        jmpEnable;
  logic        branchEnable;
  logic [7:0]  inm;
  logic [9:0]  memDir;
  logic [5:0]  branchDir;
  logic [9:0]  jmpDir;
  logic [5:0]  opCode;

  modport master (
    output in, flagA, flagB,
    input  selA, selB, selM1, selM2, wrEnable, jmpEnable, branchEnable,
           inm, memDir, branchDir, jmpDir, opCode
  );

  modport slave (
    input  in, flagA, flagB,
    output selA, selB, selM1, selM2, wrEnable, jmpEnable, branchEnable,
           inm, memDir, branchDir, jmpDir, opCode
  );
endinterface

// File: rtl/decodec_unit.sv
// Single-stage instruction decoder: combinational opcode decode into one
// output register; all outputs clear asynchronously while reset is low.
module decodec_unit
  import decodec_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  decodec_unit_if.slave  bus
);

  ctrl_t       ctrl_d;
  ctrl_t       ctrl_q;
  logic [15:0] in_q;

  always_comb begin
    ctrl_d = decode(bus.in[15:10], bus.flagA, bus.flagB);
  end

  // Field outputs are plain slices of the registered word, so the whole
  // instruction is held rather than each overlapping field separately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      in_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      in_q   <= bus.in;
    end
  end

  assign bus.selA         = ctrl_q.sel_a;
  assign bus.selB         = ctrl_q.sel_b;
  assign bus.selM1        = ctrl_q.sel_m1;
  assign bus.selM2        = ctrl_q.sel_m2;
  assign bus.wrEnable     = ctrl_q.wr_enable;
  assign bus.jmpEnable    = ctrl_q.jmp_enable;
  assign bus.branchEnable = ctrl_q.branch_enable;
  assign bus.inm          = in_q[7:0];
  assign bus.memDir       = in_q[9:0];
  assign bus.branchDir    = in_q[5:0];
  assign bus.jmpDir       = in_q[9:0];
  assign bus.opCode       = in_q[15:10];

endmodule

// File: tb/tb_decodec_unit.sv
// Self-checking bench for decodec_unit: directed vector table, reset
// sequences, full opcode sweep and randomized words against a table model.
module tb_decodec_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decodec_unit_if bus();

  decodec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] selA;
    logic [1:0] selB;
    logic       selM1;
    logic       selM2;
    logic       wr;
    logic       jmp;
    logic       br;
    logic [7:0] inm;
    logic [9:0] memDir;
    logic [5:0] branchDir;
    logic [9:0] jmpDir;
    logic [5:0] opCode;
  } out_t;

  typedef struct {
    logic [15:0] in;
    logic [2:0]  fa;
    logic [2:0]  fb;
    logic [1:0]  selA;
    logic [1:0]  selB;
    logic        m1;
    logic        m2;
    logic        wr;
    logic        jmp;
    logic        br;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Opcode map as lookup tables; brsrc indexes {flagB, flagA}, -1 = no branch.
  bit [1:0] t_selA [64];
  bit [1:0] t_selB [64];
  bit       t_m1   [64];
  bit       t_m2   [64];
  bit       t_wr   [64];
  bit       t_jmp  [64];
  int       t_brsrc[64];

  task automatic init_tables();
    for (int unsigned i = 0; i < 64; i++) begin
      t_selA[i] = 2'd0; t_selB[i] = 2'd0; t_m1[i] = 0; t_m2[i] = 0;
      t_wr[i] = 0; t_jmp[i] = 0; t_brsrc[i] = -1;
    end
    t_selA[8'h01] = 2'd3;  t_selB[8'h02] = 2'd3;
    t_selA[8'h03] = 2'd2;  t_selB[8'h04] = 2'd2;
    t_wr[8'h05] = 1;       t_wr[8'h06] = 1;  t_m1[8'h06] = 1;
    t_selA[8'h07] = 2'd1;  t_selA[8'h09] = 2'd1;
    t_selA[8'h0B] = 2'd1;  t_selA[8'h0C] = 2'd1;
    t_selB[8'h08] = 2'd1;  t_selB[8'h0A] = 2'd1;
    t_jmp[8'h0D] = 1;
    t_brsrc[8'h0E] = 0;    t_brsrc[8'h0F] = 3;
    t_brsrc[8'h10] = 1;    t_brsrc[8'h11] = 2;
    t_selA[8'h12] = 2'd1;  t_m2[8'h12] = 1;
    t_selB[8'h13] = 2'd1;  t_m2[8'h13] = 1;
  endtask

  function automatic out_t with_fields(logic [15:0] w, out_t o);
    out_t r = o;
    r.inm       = w[7:0];
    r.memDir    = w[9:0];
    r.branchDir = w[5:0];
    r.jmpDir    = w[9:0];
    r.opCode    = w[15:10];
    return r;
  endfunction

  function automatic out_t model(logic [15:0] w, logic [2:0] fa, logic [2:0] fb);
    out_t       o  = '0;
    int         op = int'(w[15:10]);
    logic [5:0] fl = {fb, fa};
    o.selA  = t_selA[op];
    o.selB  = t_selB[op];
    o.selM1 = t_m1[op];
    o.selM2 = t_m2[op];
    o.wr    = t_wr[op];
    o.jmp   = t_jmp[op];
    if (t_brsrc[op] >= 0) o.br = fl[t_brsrc[op]];
    return with_fields(w, o);
  endfunction

  function automatic out_t sample();
    out_t o;
    o.selA      = bus.selA;
    o.selB      = bus.selB;
    o.selM1     = bus.selM1;
    o.selM2     = bus.selM2;
    o.wr        = bus.wrEnable;
    o.jmp       = bus.jmpEnable;
    o.br        = bus.branchEnable;
    o.inm       = bus.inm;
    o.memDir    = bus.memDir;
    o.branchDir = bus.branchDir;
    o.jmpDir    = bus.jmpDir;
    o.opCode    = bus.opCode;
    return o;
  endfunction

  task automatic check(string name, out_t exp);
    out_t act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_exclusive(string name);
    int unsigned cnt = 32'(bus.wrEnable) + 32'(bus.jmpEnable) + 32'(bus.branchEnable);
    n_cmp++;
    if (cnt > 1) begin
      n_fail++;
      $display("FAIL %s: %0d strobes active, at most 1 allowed", name, cnt);
    end
  endtask

  task automatic apply(logic [15:0] w, logic [2:0] fa, logic [2:0] fb);
    @(negedge clk);
    bus.in    = w;
    bus.flagA = fa;
    bus.flagB = fb;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    out_t e;
    init_tables();

    vecs[0]  = '{16'h0000, 3'b000, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 0};
    vecs[1]  = '{16'h0C5A, 3'b000, 3'b000, 2'd2, 2'd0, 0, 0, 0, 0, 0};
    vecs[2]  = '{16'h1555, 3'b000, 3'b000, 2'd0, 2'd0, 0, 0, 1, 0, 0};
    vecs[3]  = '{16'h1800, 3'b000, 3'b000, 2'd0, 2'd0, 1, 0, 1, 0, 0};
    vecs[4]  = '{16'h1C00, 3'b000, 3'b000, 2'd1, 2'd0, 0, 0, 0, 0, 0};
    vecs[5]  = '{16'h4811, 3'b000, 3'b000, 2'd1, 2'd0, 0, 1, 0, 0, 0};
    vecs[6]  = '{16'h37FF, 3'b111, 3'b111, 2'd0, 2'd0, 0, 0, 0, 1, 0};
    vecs[7]  = '{16'h382A, 3'b001, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 1};
    vecs[8]  = '{16'h382A, 3'b110, 3'b111, 2'd0, 2'd0, 0, 0, 0, 0, 0};
    vecs[9]  = '{16'h3C15, 3'b000, 3'b001, 2'd0, 2'd0, 0, 0, 0, 0, 1};
    vecs[10] = '{16'h4003, 3'b010, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 1};
    vecs[11] = '{16'h4407, 3'b100, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 1};
    vecs[12] = '{16'h4C99, 3'b000, 3'b000, 2'd0, 2'd1, 0, 1, 0, 0, 0};
    vecs[13] = '{16'hFFFF, 3'b111, 3'b111, 2'd0, 2'd0, 0, 0, 0, 0, 0};

    // Reset held across an edge.
    reset     = 1'b0;
    bus.in    = 16'h3400;
    bus.flagA = 3'b000;
    bus.flagB = 3'b000;
    @(posedge clk);
    #1;
    check("reset_state", '0);

    @(negedge clk);
    reset = 1'b1;
    apply(16'h3400, 3'b000, 3'b000);
    check("jmp_before_reset", model(16'h3400, 3'b000, 3'b000));

    // Reset asserted mid-cycle clears outputs before any clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", '0);
    @(posedge clk);
    #1;
    check("reset_holds_over_edge", '0);

    @(negedge clk);
    bus.in = 16'h0000;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    check("release_nop", '0);

    foreach (vecs[i]) begin
      apply(vecs[i].in, vecs[i].fa, vecs[i].fb);
      e       = '0;
      e.selA  = vecs[i].selA;
      e.selB  = vecs[i].selB;
      e.selM1 = vecs[i].m1;
      e.selM2 = vecs[i].m2;
      e.wr    = vecs[i].wr;
      e.jmp   = vecs[i].jmp;
      e.br    = vecs[i].br;
      check($sformatf("vec%0d_%h", i, vecs[i].in), with_fields(vecs[i].in, e));
    end

    for (int unsigned op = 0; op < 64; op++) begin
      logic [15:0] w;
      w = {op[5:0], 10'($urandom)};
      apply(w, 3'b000, 3'b000);
      check($sformatf("sweep_op%02h", op), model(w, 3'b000, 3'b000));
      check_exclusive($sformatf("sweep_excl_op%02h", op));
    end

    for (int unsigned n = 0; n < 400; n++) begin
      logic [15:0] w;
      logic [2:0]  fa;
      logic [2:0]  fb;
      w  = 16'($urandom);
      if (n[0]) w[15:10] = 6'($urandom_range(0, 19));
      fa = 3'($urandom);
      fb = 3'($urandom);
      apply(w, fa, fb);
      check($sformatf("rand%0d_%h_%b_%b", n, w, fa, fb), model(w, fa, fb));
    end

    // Mid-stream reset pulse during a taken branch, then resume.
    apply(16'h382A, 3'b001, 3'b000);
    check("branch_before_pulse", model(16'h382A, 3'b001, 3'b000));
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_pulse", '0);
    @(negedge clk);
    reset = 1'b1;
    apply(16'h0C5A, 3'b000, 3'b000);
    check("ldca_after_release", model(16'h0C5A, 3'b000, 3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decodec_unit.md
# decodec_unit

Instruction decoder for the two-accumulator (A/B) datapath. Each clock it registers one 16-bit instruction word plus both accumulator flag sets and drives the control strobes and extracted fields. The outputs steer the register-source muxes, the ALU, data memory writes and the PC jump/branch logic. Module name: `decodec`. Opcode constants live in `def.v`.

## Interface
Parameters: none. All widths are fixed by the ISA.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low; clears all outputs.
- `in` input 16: instruction word.
- `flagA` input 3: accumulator A flags {C,N,Z} (bit2 C, bit1 N, bit0 Z).
- `flagB` input 3: accumulator B flags, same layout.
- `selA` output 2: A load source: 00 hold, 01 ALU result, 10 `inm`, 11 memory.
- `selB` output 2: B load source, same encoding.
- `selM1` output 1: memory write-data source: 0 A, 1 B.
- `selM2` output 1: ALU second operand: 0 other accumulator, 1 `inm`.
- `wrEnable` output 1: data-memory write strobe.
- `jmpEnable` output 1: unconditional jump.
- `branchEnable` output 1: taken conditional branch.
- `inm` output 8: immediate, `in[7:0]`.
- `memDir` output 10: memory address, `in[9:0]`.
- `branchDir` output 6: relative branch offset, `in[5:0]`.
- `jmpDir` output 10: absolute jump target, `in[9:0]`.
- `opCode` output 6: `in[15:10]`, forwarded to the ALU.

## Operation
Opcode map. Any opcode not listed gets the zero-control value.
- 0x00 NOP: all controls zero.
- 0x01 LDA: selA=11.
- 0x02 LDB: selB=11.
- 0x03 LDCA: selA=10.
- 0x04 LDCB: selB=10.
- 0x05 STA: wrEnable=1, selM1=0.
- 0x06 STB: wrEnable=1, selM1=1.
- A+B ops, selM2=0:
  - 0x07 ADDA and 0x09 SUBA: selA=01.
  - 0x08 ADDB and 0x0A SUBB: selB=01.
  - 0x0B ANDA and 0x0C ORA: selA=01.
- 0x0D JMP: jmpEnable=1.
- 0x0E BAZ: branchEnable=flagA[0].
- 0x0F BBZ: branchEnable=flagB[0].
- 0x10 BAN: branchEnable=flagA[1].
- 0x11 BAC: branchEnable=flagA[2].
- 0x12 ADDCA: selA=01, selM2=1.
- 0x13 ADDCB: selB=01, selM2=1.

Zero-control value: every control output 0, with `selA`/`selB`=00 (hold).

Rules that hold for every opcode:
- Field outputs (`inm`, `memDir`, `branchDir`, `jmpDir`, `opCode`) are extracted every cycle regardless of opcode.
- `opCode` is forwarded unmodified, including for undefined opcodes.
- At most one of `wrEnable`, `jmpEnable`, `branchEnable` is ever 1.
- `branchEnable` is 0 when the selected flag is 0, for any branch opcode.

## Timing
- All outputs are registered on the rising `clk` edge: 1-cycle latency from `in`/`flags` to outputs.
- A new instruction is accepted every cycle; there is no handshake.
- Flags are sampled in the same cycle as the instruction that tests them.
- While `reset`=0 every output is 0 (NOP state). This applies immediately, without waiting for a clock, including mid-stream.
- After `reset` rises, the first edge registers the current `in`.
- If `in` is undefined (X) when sampled, outputs carry X. No protection is required.

## Structure
- Shared package/include `def.v`: holds the 6-bit opcode constants (`OP_NOP` … `OP_ADDCB`), the 2-bit `SEL_HOLD`/`SEL_ALU`/`SEL_INM`/`SEL_MEM` codes, and flag bit indices (`FLAG_Z`, `FLAG_N`, `FLAG_C`).
- Internal structure: one combinational decode (case on opcode) feeding one output register stage.
- No sub-module is needed.

## Test plan
- Reset: drive `reset`=0 mid-stream with `in`=0x3400 (JMP) → all outputs 0 asynchronously. Release and apply 0x0000 → all controls 0.
- Loads/stores:
  - `in`=0x0C5A (LDCA, inm 0x5A) → next edge: selA=10, inm=0x5A, opCode=0x03.
  - `in`=0x1555 (STA) → wrEnable=1, selM1=0, memDir=0x155.
- ALU:
  - 0x1C00 (ADDA) → selA=01, selM2=0, opCode=0x07.
  - 0x4811 (ADDCA) → selA=01, selM2=1, inm=0x11.
- Jump: `in`=0x37FF → jmpEnable=1, jmpDir=0x3FF, branchEnable=0.
- Branch: `in`=0x382A (BAZ) with flagA=001 → branchEnable=1, branchDir=0x2A. Same word with flagA=110 → branchEnable=0.
- Sweep: opcodes 0x00–0x3F one per cycle, flags 000 → each output matches the map one cycle later; undefined opcodes give the zero-control value with `opCode` echoed.
